// File: rtl/crc8_frame_sched.sv
// Byte-to-bit scheduler for a serial CRC-8 engine: shifts framed bytes out MSB first,
// waits for the engine's done flag (bounded by a timeout) and holds the result for a consumer.
module crc8_frame_sched #(
  parameter int DONE_TIMEOUT = 4,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       bit_last,
  input  logic [7:0] crc_in,
  input  logic       crc_done_in,
  output logic [7:0] res_crc,
  output logic [7:0] res_len,
  output logic       res_err,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);
  localparam int            TW        = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [7:0]    LEN_MAX   = 8'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DONE, RESULT} state_t;

  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          last_q, last_nx;
  logic [7:0]    len, len_nx;
  logic [TW-1:0] wcnt, wcnt_nx;
  logic [7:0]    res_crc_nx, res_len_nx;
  logic          res_err_nx;
  logic          ready_c;
  logic [7:0]    len_inc;

  assign len_inc   = len + 8'd1;
  // State already reads IDLE during reset, so the handshake is masked explicitly.
  assign s_ready   = ready_c & ~rst;
  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid & shreg[~cnt];
  assign bit_last  = bit_valid & (cnt == 3'd7) & last_q;
  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx   = state;
    cnt_nx     = cnt;
    shreg_nx   = shreg;
    last_nx    = last_q;
    len_nx     = len;
    wcnt_nx    = wcnt;
    res_crc_nx = res_crc;
    res_len_nx = res_len;
    res_err_nx = res_err;
    ready_c    = 1'b0;

    unique case (state)
      IDLE: ready_c = 1'b1;
      SHIFT: begin
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) begin
          if (last_q) begin
            state_nx = WAIT_DONE;
            wcnt_nx  = '0;
          end else begin
            ready_c  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        wcnt_nx = wcnt + 1'b1;
        if (crc_done_in) begin
          res_crc_nx = crc_in;
          res_err_nx = 1'b0;
          res_len_nx = len;
          state_nx   = RESULT;
        end else if (wcnt == WAIT_LAST) begin
          res_crc_nx = 8'h00;
          res_err_nx = 1'b1;
          res_len_nx = len;
          state_nx   = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          len_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Acceptance is shared by IDLE and the cnt==7 handoff, which keeps bit_valid gap-free.
    if (ready_c && s_valid) begin
      shreg_nx = s_data;
      last_nx  = s_last | (len_inc == LEN_MAX);
      len_nx   = len_inc;
      cnt_nx   = '0;
      state_nx = SHIFT;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
      len     <= '0;
      wcnt    <= '0;
      res_crc <= '0;
      res_len <= '0;
      res_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shreg   <= shreg_nx;
      last_q  <= last_nx;
      len     <= len_nx;
      wcnt    <= wcnt_nx;
      res_crc <= res_crc_nx;
      res_len <= res_len_nx;
      res_err <= res_err_nx;
    end
  end

endmodule

// File: doc/crc8_frame_sched.md
CRC8_FRAME_SCHED -- requirements
Module: crc8_frame_sched

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 4: maximum cycles in WAIT_DONE before a timeout error.
REQ-002 SHALL have parameter MAX_BYTES, default 64: maximum bytes per frame; the final byte is forced as last.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port s_data, input, 8 bits: message byte, shifted MSB first.
REQ-006 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 SHALL have port s_last, input, 1 bit: s_data is the final byte of the frame.
REQ-008 SHALL have port s_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-009 SHALL have port bit_out, output, 1 bit: serial bit to the CRC engine data_in.
REQ-010 SHALL have port bit_valid, output, 1 bit: drives the CRC engine data_valid.
REQ-011 SHALL have port bit_last, output, 1 bit: drives the CRC engine last_bit.
REQ-012 SHALL have port crc_in, input, 8 bits: the CRC engine crc_out.
REQ-013 SHALL have port crc_done_in, input, 1 bit: the CRC engine crc_done.
REQ-014 SHALL have port res_crc, output, 8 bits: captured CRC result.
REQ-015 SHALL have port res_len, output, 8 bits: byte count of the completed frame.
REQ-016 SHALL have port res_err, output, 1 bit: timeout occurred for this frame.
REQ-017 SHALL have port res_valid, output, 1 bit: result fields are valid.
REQ-018 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-019 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, SHIFT, WAIT_DONE and RESULT.
REQ-021 In IDLE, SHALL drive s_ready=1, bit_valid=0 and bit_last=0.
REQ-022 In IDLE, on s_valid&s_ready SHALL capture s_data, capture last = s_last | (len+1==MAX_BYTES), increment len, and go to SHIFT.
REQ-023 In SHIFT, SHALL hold bit_valid=1 for exactly 8 cycles, driving bit_out=byte[7-cnt] for cnt 0..7.
REQ-024 In SHIFT, bit_last SHALL be 1 only at cnt==7 and only if captured last is set.
REQ-025 In SHIFT at cnt==7 with last=0, SHALL drive s_ready=1; if a byte is accepted, SHALL load it and restart cnt=0 in SHIFT with no bit_valid gap.
REQ-026 In SHIFT at cnt==7 with last=0 and no byte accepted, SHALL go to IDLE; bit_valid drops and the engine holds its state.
REQ-027 In SHIFT at cnt==7 with last=1, SHALL go to WAIT_DONE; s_ready SHALL be 0.
REQ-028 In WAIT_DONE, SHALL drive bit_valid=0 and s_ready=0 and count cycles from 0.
REQ-029 In WAIT_DONE, on crc_done_in SHALL latch res_crc=crc_in and res_err=0, then go to RESULT.
REQ-030 In WAIT_DONE, if the count reaches DONE_TIMEOUT with no crc_done_in, SHALL set res_crc=0x00 and res_err=1, then go to RESULT.
REQ-031 crc_done_in SHALL be ignored outside WAIT_DONE.
REQ-032 In RESULT, SHALL hold res_valid=1 and all res_* fields stable until res_ready is seen.
REQ-033 In RESULT, on res_ready SHALL clear len and go to IDLE; res_valid falls the next cycle.
REQ-034 Latency SHALL be: byte accepted at edge T gives bits at cycles T+1..T+8; with crc_done at T+9, res_valid is high from T+10.
REQ-035 res_len SHALL equal the number of bytes accepted in the frame, range 1..MAX_BYTES.

Reset
REQ-036 While rst=1, regardless of clk, SHALL force state=IDLE, cnt=0 and len=0.
REQ-037 While rst=1, SHALL force bit_out, bit_valid, bit_last, res_valid, res_err and busy to 0, and res_crc and res_len to 0x00.
REQ-038 s_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after release.
REQ-039 Reset asserted mid-SHIFT or mid-WAIT_DONE SHALL abandon the frame with no res_valid pulse.

Verification
REQ-040 Bytes 0x48 then 0x69, 0x69 with s_last, engine stub answering crc_done=1 with crc_out=0xA5 one cycle after bit_last -> bit_out is 0100100001101001 over 16 consecutive bit_valid cycles, bit_last only on bit 16, res_crc=0xA5, res_len=2, res_err=0.
REQ-041 Single byte 0xFF with s_last and the stub never asserting done -> after 4 WAIT_DONE cycles, res_valid=1, res_err=1, res_crc=0x00, res_len=1.
REQ-042 MAX_BYTES=3, four bytes with no s_last -> bit_last on the 24th bit, res_len=3, and the 4th byte is not accepted until after RESULT.
REQ-043 res_ready held 0 for 5 cycles -> res_valid and fields stable, s_ready=0 throughout; on res_ready=1 the block returns to IDLE.
REQ-044 rst pulsed during SHIFT cnt=4 -> bit_valid drops immediately, no res_valid, and the next frame runs normally.
REQ-045 Spurious crc_done_in during SHIFT and IDLE -> ignored, and res_crc captures only the WAIT_DONE value.
